// File: rtl/axi_master_bridge.sv
// ---------------------------------------------------------------------------
// axi_master_bridge
// Turns CPU memory requests into AXI master transactions. Reads are single
// beats or INCR bursts of up to 16 beats; writes are single beats with byte
// strobes. Read beats and write completions return on one response port that
// has no back-pressure.
//
// Optional feature (define the macro to enable it):
//   AXI_MASTER_AW_W_CONCURRENT_EN - a write presents AW and W together; each
//   valid drops on its own handshake, and the bridge waits for B once both
//   channels have completed. Left undefined, a write runs strictly AW then W.
// ---------------------------------------------------------------------------
module axi_master_bridge #(
   parameter logic [3:0] MASTER_ID = 4'd0,
   parameter int         ADDR_W    = 32,
   parameter int         DATA_W    = 32,
   parameter int         LEN_W     = 4
) (
   input  logic                clk,
   input  logic                rst,

   // CPU request port
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [LEN_W-1:0]    req_len,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,

   // CPU response port
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_last,
   output logic                rsp_err,

   // AXI read address channel
   output logic [3:0]          M_ARID,
   output logic [ADDR_W-1:0]   M_ARAddr,
   output logic [LEN_W-1:0]    M_ARLen,
   output logic [2:0]          M_ARSize,
   output logic [1:0]          M_ARBurst,
   output logic                M_ARValid,
   input  logic                M_ARReady,

   // AXI read data channel
   input  logic [3:0]          M_RID,
   input  logic [DATA_W-1:0]   M_RData,
   input  logic [1:0]          M_RResp,
   input  logic                M_RLast,
   input  logic                M_RValid,
   output logic                M_RReady,

   // AXI write address channel
   output logic [3:0]          M_AWID,
   output logic [ADDR_W-1:0]   M_AWAddr,
   output logic [LEN_W-1:0]    M_AWLen,
   output logic [2:0]          M_AWSize,
   output logic [1:0]          M_AWBurst,
   output logic                M_AWValid,
   input  logic                M_AWReady,

   // AXI write data channel
   output logic [DATA_W-1:0]   M_WData,
   output logic [DATA_W/8-1:0] M_WStrb,
   output logic                M_WLast,
   output logic                M_WValid,
   input  logic                M_WReady,

   // AXI write response channel
   input  logic [3:0]          M_BID,
   input  logic [1:0]          M_BResp,
   input  logic                M_BValid,
   output logic                M_BReady
);

   localparam int          STRB_W     = DATA_W / 8;
   localparam logic [2:0]  AXI_SIZE   = 3'b010;   // 4-byte beats
   localparam logic [1:0]  AXI_INCR   = 2'b01;
   localparam logic [1:0]  AXI_OKAY   = 2'b00;

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      AW,
      W,
      B
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic                ar_valid_q;
   logic                aw_valid_q;
   logic                w_valid_q;
   logic                r_ready_q;
   logic                b_ready_q;
   // One bit wider than the length field so a 16-beat burst can be counted
   // and an over-long burst can be told apart from a correct one.
   logic [LEN_W:0]      beat_cnt;

   logic                r_beat;
   logic                b_hs;

`ifdef AXI_MASTER_AW_W_CONCURRENT_EN
   logic                aw_hs;
   logic                w_hs;
   logic                aw_done;
   logic                w_done;

   assign aw_hs   = aw_valid_q & M_AWReady;
   assign w_hs    = w_valid_q & M_WReady;
   // A channel counts as done if it handshakes now or already has.
   assign aw_done = aw_hs | ~aw_valid_q;
   assign w_done  = w_hs | ~w_valid_q;
`endif

   assign r_beat    = r_ready_q & M_RValid;
   assign b_hs      = b_ready_q & M_BValid;

   assign req_ready = (state == IDLE);

   // Bus-side outputs come only from captured request registers.
   assign M_ARID    = MASTER_ID;
   assign M_ARAddr  = addr_q;
   assign M_ARLen   = len_q;
   assign M_ARSize  = AXI_SIZE;
   assign M_ARBurst = AXI_INCR;
   assign M_ARValid = ar_valid_q;
   assign M_RReady  = r_ready_q;

   assign M_AWID    = MASTER_ID;
   assign M_AWAddr  = addr_q;
   assign M_AWLen   = '0;
   assign M_AWSize  = AXI_SIZE;
   assign M_AWBurst = AXI_INCR;
   assign M_AWValid = aw_valid_q;

   assign M_WData   = wdata_q;
   assign M_WStrb   = wstrb_q;
   assign M_WLast   = 1'b1;           // every write is a single beat
   assign M_WValid  = w_valid_q;
   assign M_BReady  = b_ready_q;

   // Response port: forwards the R or B handshake in the same cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path through the block
      // leaves it unassigned, which would otherwise infer a latch.
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_last  = 1'b0;
      rsp_err   = 1'b0;
      if (r_beat) begin
         rsp_valid = 1'b1;
         rsp_rdata = M_RData;
         rsp_last  = M_RLast;
         // The final beat also flags a burst whose length disagrees with ARLen.
         rsp_err   = (M_RResp != AXI_OKAY) || (M_RID != MASTER_ID) ||
                     (M_RLast && (beat_cnt != {1'b0, len_q}));
      end else if (b_hs) begin
         rsp_valid = 1'b1;
         rsp_last  = 1'b1;
         rsp_err   = (M_BResp != AXI_OKAY) || (M_BID != MASTER_ID);
      end
   end

   // Transaction FSM with registered channel valids/readies.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         ar_valid_q <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         r_ready_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         beat_cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees the pre-edge value of every other one regardless of order.
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q   <= req_addr;
                  len_q    <= req_len;
                  wdata_q  <= req_wdata;
                  wstrb_q  <= req_wstrb;
                  beat_cnt <= '0;
                  if (req_write) begin
                     state      <= AW;
                     aw_valid_q <= 1'b1;
`ifdef AXI_MASTER_AW_W_CONCURRENT_EN
                     w_valid_q  <= 1'b1;
`endif
                  end else begin
                     state      <= AR;
                     ar_valid_q <= 1'b1;
                  end
               end
            end

            AR: begin
               if (M_ARReady) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state      <= R;
               end
            end

            R: begin
               if (M_RValid) begin
                  if (beat_cnt != '1) begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
                  // Only RLast ends the burst, whatever the beat count says.
                  if (M_RLast) begin
                     r_ready_q <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end

            AW: begin
`ifdef AXI_MASTER_AW_W_CONCURRENT_EN
               if (aw_hs) begin
                  aw_valid_q <= 1'b0;
               end
               if (w_hs) begin
                  w_valid_q <= 1'b0;
               end
               if (aw_done && w_done) begin
                  b_ready_q <= 1'b1;
                  state     <= B;
               end else if (aw_done) begin
                  state     <= W;
               end
`else
               if (M_AWReady) begin
                  aw_valid_q <= 1'b0;
                  w_valid_q  <= 1'b1;
                  state      <= W;
               end
`endif
            end

            W: begin
               if (M_WReady) begin
                  w_valid_q <= 1'b0;
                  b_ready_q <= 1'b1;
                  state     <= B;
               end
            end

            B: begin
               if (M_BValid) begin
                  b_ready_q <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_master_bridge
// Table of read/write transactions driven through a procedural AXI slave,
// with expected CPU responses queued at stimulus time and compared by a
// response monitor. Hand-written sequences cover reset mid-burst and, when
// AXI_MASTER_AW_W_CONCURRENT_EN is defined, W completing before AW.
// ---------------------------------------------------------------------------
module tb_axi_master_bridge;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [3:0]  req_len;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_last;
   logic        rsp_err;
   logic [3:0]  M_ARID;
   logic [31:0] M_ARAddr;
   logic [3:0]  M_ARLen;
   logic [2:0]  M_ARSize;
   logic [1:0]  M_ARBurst;
   logic        M_ARValid;
   logic        M_ARReady;
   logic [3:0]  M_RID;
   logic [31:0] M_RData;
   logic [1:0]  M_RResp;
   logic        M_RLast;
   logic        M_RValid;
   logic        M_RReady;
   logic [3:0]  M_AWID;
   logic [31:0] M_AWAddr;
   logic [3:0]  M_AWLen;
   logic [2:0]  M_AWSize;
   logic [1:0]  M_AWBurst;
   logic        M_AWValid;
   logic        M_AWReady;
   logic [31:0] M_WData;
   logic [3:0]  M_WStrb;
   logic        M_WLast;
   logic        M_WValid;
   logic        M_WReady;
   logic [3:0]  M_BID;
   logic [1:0]  M_BResp;
   logic        M_BValid;
   logic        M_BReady;

   axi_master_bridge dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_last  (rsp_last),
      .rsp_err   (rsp_err),
      .M_ARID    (M_ARID),
      .M_ARAddr  (M_ARAddr),
      .M_ARLen   (M_ARLen),
      .M_ARSize  (M_ARSize),
      .M_ARBurst (M_ARBurst),
      .M_ARValid (M_ARValid),
      .M_ARReady (M_ARReady),
      .M_RID     (M_RID),
      .M_RData   (M_RData),
      .M_RResp   (M_RResp),
      .M_RLast   (M_RLast),
      .M_RValid  (M_RValid),
      .M_RReady  (M_RReady),
      .M_AWID    (M_AWID),
      .M_AWAddr  (M_AWAddr),
      .M_AWLen   (M_AWLen),
      .M_AWSize  (M_AWSize),
      .M_AWBurst (M_AWBurst),
      .M_AWValid (M_AWValid),
      .M_AWReady (M_AWReady),
      .M_WData   (M_WData),
      .M_WStrb   (M_WStrb),
      .M_WLast   (M_WLast),
      .M_WValid  (M_WValid),
      .M_WReady  (M_WReady),
      .M_BID     (M_BID),
      .M_BResp   (M_BResp),
      .M_BValid  (M_BValid),
      .M_BReady  (M_BReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard of expected CPU responses.
   typedef struct {
      logic        chk_data;
      logic [31:0] rdata;
      logic        last;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];

   task automatic push_rsp(input logic chk_data, input logic [31:0] rdata,
                           input logic last, input logic err);
      rsp_t r;
      r.chk_data = chk_data;
      r.rdata    = rdata;
      r.last     = last;
      r.err      = err;
      exp_q.push_back(r);
   endtask

   // Every response pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual=pulse rdata=%0h expected=none", rsp_rdata);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            if (e.chk_data) check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_last", rsp_last, e.last);
            check("rsp_err", rsp_err, e.err);
         end
      end
   end

   // Transaction table: dly_a = AR/AW ready delay, dly_b = R beat gap or
   // W ready delay, beats = beats the slave returns, exp_err = error on the
   // final response pulse.
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [31:0] data;
      logic [31:0] step;
      logic [3:0]  strb;
      int          dly_a;
      int          dly_b;
      int          beats;
      logic [1:0]  resp;
      logic [3:0]  id;
      logic        exp_err;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input vec_t v);
      logic [31:0] d;
      logic        base_err;
      check("rd_req_ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = v.addr;
      req_len   = v.len;
      tick();
      req_valid = 1'b0;
      check("ar_valid", M_ARValid, 1'b1);
      check("ar_addr", M_ARAddr, v.addr);
      check("ar_len", M_ARLen, v.len);
      check("ar_size_burst_id", {M_ARSize, M_ARBurst, M_ARID}, {3'b010, 2'b01, 4'd0});
      check("rd_req_ready_busy", req_ready, 1'b0);
      for (int i = 0; i < v.dly_a; i++) tick();
      check("ar_valid_held", M_ARValid, 1'b1);
      M_ARReady = 1'b1;
      tick();
      M_ARReady = 1'b0;
      check("ar_valid_drop", M_ARValid, 1'b0);
      check("r_ready", M_RReady, 1'b1);
      base_err = (v.resp != 2'b00) || (v.id != 4'd0);
      for (int b = 0; b < v.beats; b++) begin
         for (int g = 0; g < v.dly_b; g++) tick();
         d        = v.data + v.step * b;
         M_RValid = 1'b1;
         M_RData  = d;
         M_RResp  = v.resp;
         M_RID    = v.id;
         M_RLast  = (b == v.beats - 1);
         push_rsp(1'b1, d, M_RLast, M_RLast ? v.exp_err : base_err);
         tick();
         M_RValid = 1'b0;
         M_RLast  = 1'b0;
      end
      check("rd_done_req_ready", req_ready, 1'b1);
      check("rd_done_r_ready", M_RReady, 1'b0);
   endtask

   task automatic do_write(input vec_t v);
      logic exp_wv_first;
`ifdef AXI_MASTER_AW_W_CONCURRENT_EN
      exp_wv_first = 1'b1;
`else
      exp_wv_first = 1'b0;
`endif
      check("wr_req_ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = v.addr;
      req_len   = 4'hF;            // ignored for writes
      req_wdata = v.data;
      req_wstrb = v.strb;
      tick();
      req_valid = 1'b0;
      check("aw_valid", M_AWValid, 1'b1);
      check("aw_addr", M_AWAddr, v.addr);
      check("aw_len", M_AWLen, 4'd0);
      check("aw_size_burst_id", {M_AWSize, M_AWBurst, M_AWID}, {3'b010, 2'b01, 4'd0});
      check("w_valid_at_aw", M_WValid, exp_wv_first);
      for (int i = 0; i < v.dly_a; i++) tick();
      check("aw_valid_held", M_AWValid, 1'b1);
      M_AWReady = 1'b1;
      tick();
      M_AWReady = 1'b0;
      check("aw_valid_drop", M_AWValid, 1'b0);
      check("w_valid", M_WValid, 1'b1);
      check("w_last", M_WLast, 1'b1);
      check("w_data", M_WData, v.data);
      check("w_strb", M_WStrb, v.strb);
      for (int i = 0; i < v.dly_b; i++) tick();
      M_WReady = 1'b1;
      tick();
      M_WReady = 1'b0;
      check("w_valid_drop", M_WValid, 1'b0);
      check("b_ready", M_BReady, 1'b1);
      tick();
      M_BValid = 1'b1;
      M_BResp  = v.resp;
      M_BID    = v.id;
      push_rsp(1'b0, 32'h0, 1'b1, v.exp_err);
      tick();
      M_BValid = 1'b0;
      check("wr_done_req_ready", req_ready, 1'b1);
      check("wr_done_b_ready", M_BReady, 1'b0);
   endtask

   vec_t vecs[10];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //               wr    addr          len   data          step      strb   da db bt resp   id     err
      vecs[0] = '{1'b0, 32'h0000_1000, 4'd0,  32'hDEAD_BEEF, 32'h0,    4'h0, 2, 0, 1, 2'b00, 4'd0, 1'b0};
      vecs[1] = '{1'b0, 32'h0000_2000, 4'd3,  32'h11,        32'h11,   4'h0, 0, 2, 4, 2'b00, 4'd0, 1'b0};
      vecs[2] = '{1'b1, 32'h0000_0300, 4'd0,  32'h0000_00FF, 32'h0,    4'h1, 3, 0, 1, 2'b00, 4'd0, 1'b0};
      vecs[3] = '{1'b0, 32'h0000_0040, 4'd1,  32'hA5A5_0000, 32'h1,    4'h0, 1, 1, 2, 2'b10, 4'd0, 1'b1};
      vecs[4] = '{1'b1, 32'h0000_0044, 4'd0,  32'h1234_5678, 32'h0,    4'hF, 0, 1, 1, 2'b00, 4'd5, 1'b1};
      vecs[5] = '{1'b1, 32'h0000_0048, 4'd0,  32'hCAFE_F00D, 32'h0,    4'hC, 1, 2, 1, 2'b11, 4'd0, 1'b1};
      vecs[6] = '{1'b0, 32'h0000_3000, 4'd3,  32'h100,       32'h4,    4'h0, 0, 0, 2, 2'b00, 4'd0, 1'b1};
      vecs[7] = '{1'b0, 32'h0000_3100, 4'd0,  32'h200,       32'h8,    4'h0, 0, 1, 2, 2'b00, 4'd0, 1'b1};
      vecs[8] = '{1'b0, 32'h0000_3200, 4'd0,  32'h0BAD_0001, 32'h0,    4'h0, 1, 0, 1, 2'b00, 4'd3, 1'b1};
      vecs[9] = '{1'b0, 32'h0000_4000, 4'd15, 32'h1000_0000, 32'h1111, 4'h0, 0, 0, 16, 2'b00, 4'd0, 1'b0};

      rst       = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_len   = '0;
      req_wdata = '0;
      req_wstrb = '0;
      M_ARReady = 1'b0;
      M_RID     = '0;
      M_RData   = '0;
      M_RResp   = '0;
      M_RLast   = 1'b0;
      M_RValid  = 1'b0;
      M_AWReady = 1'b0;
      M_WReady  = 1'b0;
      M_BID     = '0;
      M_BResp   = '0;
      M_BValid  = 1'b0;

      // Reset values.
      repeat (2) @(posedge clk);
      #2;
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_valids", {M_ARValid, M_AWValid, M_WValid}, 3'b000);
      check("rst_readies", {M_RReady, M_BReady}, 2'b00);
      check("rst_rsp", {rsp_valid, rsp_last, rsp_err}, 3'b000);
      check("rst_regs", {M_ARAddr, M_ARLen, M_WStrb}, 40'h0);
      check("rst_wdata", M_WData, 32'h0);
      tick();
      rst = 1'b1;
      tick();

      // Table-driven transactions, issued back to back.
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wr) do_write(vecs[i]);
         else            do_read(vecs[i]);
      end

      // Reset asserted in R after 1 of 4 beats.
      begin
         vec_t v;
         check("mid_req_ready", req_ready, 1'b1);
         req_valid = 1'b1;
         req_write = 1'b0;
         req_addr  = 32'h0000_5000;
         req_len   = 4'd3;
         tick();
         req_valid = 1'b0;
         M_ARReady = 1'b1;
         tick();
         M_ARReady = 1'b0;
         check("mid_r_ready", M_RReady, 1'b1);
         M_RValid  = 1'b1;
         M_RData   = 32'h5555_0000;
         M_RResp   = 2'b00;
         M_RID     = 4'd0;
         push_rsp(1'b1, 32'h5555_0000, 1'b0, 1'b0);
         tick();
         M_RData   = 32'h5555_0001;   // second beat offered as reset hits
         rst       = 1'b0;
         #2;
         check("mid_rst_valids", {M_ARValid, M_AWValid, M_WValid}, 3'b000);
         check("mid_rst_readies", {M_RReady, M_BReady}, 2'b00);
         check("mid_rst_req_ready", req_ready, 1'b1);
         check("mid_rst_no_rsp", rsp_valid, 1'b0);
         tick();
         M_RValid  = 1'b0;
         rst       = 1'b1;
         tick();
         v = '{1'b0, 32'h0000_6000, 4'd1, 32'h7700, 32'h1, 4'h0, 1, 0, 2, 2'b00, 4'd0, 1'b0};
         do_read(v);
      end

`ifdef AXI_MASTER_AW_W_CONCURRENT_EN
      // W handshake completes before AW.
      begin
         req_valid = 1'b1;
         req_write = 1'b1;
         req_addr  = 32'h0000_0700;
         req_wdata = 32'h0F0F_0F0F;
         req_wstrb = 4'h3;
         tick();
         req_valid = 1'b0;
         check("cc_both_valid", {M_AWValid, M_WValid}, 2'b11);
         M_WReady = 1'b1;
         tick();
         M_WReady = 1'b0;
         check("cc_w_first_drop", {M_AWValid, M_WValid}, 2'b10);
         check("cc_no_b_yet", M_BReady, 1'b0);
         tick();
         check("cc_aw_held", M_AWValid, 1'b1);
         M_AWReady = 1'b1;
         tick();
         M_AWReady = 1'b0;
         check("cc_both_drop", {M_AWValid, M_WValid}, 2'b00);
         check("cc_b_ready", M_BReady, 1'b1);
         M_BValid = 1'b1;
         M_BResp  = 2'b00;
         M_BID    = 4'd0;
         push_rsp(1'b0, 32'h0, 1'b1, 1'b0);
         tick();
         M_BValid = 1'b0;
         check("cc_req_ready", req_ready, 1'b1);
      end
`endif

      repeat (3) tick();
      check("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
